// File: rtl/constants.sv
// Shared FPU definitions: operation codes, special-value flags, GRS width and
// a canonical quiet-NaN constructor usable for any EW/SW binary format.
package constants;

    typedef enum logic [2:0] {
        FPU_ADD = 3'd0,
        FPU_SUB = 3'd1,
        FPU_MUL = 3'd2,
        FPU_DIV = 3'd3,
        FPU_CMP = 3'd4
    } fpuOp_t;

    typedef struct packed {
        logic isNaN;
        logic isInf;
        logic isZero;
    } fpuFlags_t;

    localparam int FPU_GRS_W = 3;

    // Sign 0, exponent all-ones, significand MSB set; caller truncates to 1+ew+sw bits.
    function automatic logic [63:0] fpu_canonical_nan(input int ew, input int sw);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < ew; i++) r[sw + i] = 1'b1;
        r[sw - 1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Leading-zero counter; returns W when the input is all zeros.
module fpu_lzc #(
    parameter  int W  = 14,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  value,
    output logic [CW-1:0] count
);

    // NOTE: the default assignment before the loop keeps this purely combinational (no latch).
    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (value[i]) count = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/fpu_addsub_pipe.sv
// Three-stage IEEE-754-style add/sub (align, add/normalise, round/pack) with
// round-to-nearest-even, subnormals, specials and a single global stall.
module fpu_addsub_pipe
    import constants::*;
#(
    parameter  int EW = 5,
    parameter  int SW = 10,
    localparam int BW = 1 + EW + SW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          inValid,
    output logic          inReady,
    input  logic [BW-1:0] fpuIn1,
    input  logic [BW-1:0] fpuIn2,
    input  fpuOp_t        op,
    input  logic [3:0]    inTag,
    output logic          outValid,
    input  logic          outReady,
    output logic [BW-1:0] fpuOut,
    output logic [3:0]    condCodes,
    output logic [3:0]    outTag
);

    localparam int M = SW + 1 + FPU_GRS_W;
    localparam logic [EW-1:0] EXP_MAX = '1;
    localparam logic [BW-1:0] QNAN = BW'(fpu_canonical_nan(EW, SW));

    typedef struct packed {
        logic          valid;
        logic [3:0]    tag;
        logic          sign;
        logic [EW-1:0] exp;
        logic [M-1:0]  sig_big;
        logic [M-1:0]  sig_small;
        logic          eff_sub;
        fpuFlags_t     flags;
    } s1_t;

    typedef struct packed {
        logic          valid;
        logic [3:0]    tag;
        logic          sign;
        logic [EW-1:0] exp;
        logic [M-1:0]  sig;
        fpuFlags_t     flags;
    } s2_t;

    s1_t s1, s1_next;
    s2_t s2, s2_next;
    logic advance;

    assign advance = !outValid || outReady;
    assign inReady = advance;

    // ---------------- stage 1: unpack, swap, align ----------------
    logic a_sign, b_sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
    logic [EW-1:0] a_e, b_e, a_ex, b_ex, big_ex, small_ex, diff;
    logic [SW-1:0] a_f, b_f;
    logic [M-1:0]  a_sig, b_sig, big_sig, small_sig, lost, small_al;

    assign a_sign = fpuIn1[BW-1];
    assign b_sign = fpuIn2[BW-1] ^ (op == FPU_SUB);
    assign a_e    = fpuIn1[BW-2:SW];
    assign b_e    = fpuIn2[BW-2:SW];
    assign a_f    = fpuIn1[SW-1:0];
    assign b_f    = fpuIn2[SW-1:0];

    always_comb begin
        a_zero = (a_e == '0) && (a_f == '0);
        b_zero = (b_e == '0) && (b_f == '0);
        a_inf  = (a_e == EXP_MAX) && (a_f == '0);
        b_inf  = (b_e == EXP_MAX) && (b_f == '0);
        a_nan  = (a_e == EXP_MAX) && (a_f != '0);
        b_nan  = (b_e == EXP_MAX) && (b_f != '0);
        // Subnormals behave as exponent 1 with a clear hidden bit.
        a_ex   = (a_e == '0) ? EW'(1) : a_e;
        b_ex   = (b_e == '0) ? EW'(1) : b_e;
        a_sig  = {a_e != '0, a_f, {FPU_GRS_W{1'b0}}};
        b_sig  = {b_e != '0, b_f, {FPU_GRS_W{1'b0}}};

        swap      = fpuIn2[BW-2:0] > fpuIn1[BW-2:0];
        big_ex    = swap ? b_ex  : a_ex;
        small_ex  = swap ? a_ex  : b_ex;
        big_sig   = swap ? b_sig : a_sig;
        small_sig = swap ? a_sig : b_sig;
        diff      = big_ex - small_ex;

        lost = small_sig & ~({M{1'b1}} << diff);
        if (int'(diff) >= M) small_al = {{(M-1){1'b0}}, |small_sig};
        else                 small_al = (small_sig >> diff) | {{(M-1){1'b0}}, |lost};

        s1_next              = '0;
        s1_next.valid        = inValid;
        s1_next.tag          = inTag;
        s1_next.exp          = big_ex;
        s1_next.sig_big      = big_sig;
        s1_next.sig_small    = small_al;
        s1_next.eff_sub      = a_sign != b_sign;
        s1_next.flags.isNaN  = a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign));
        s1_next.flags.isInf  = !s1_next.flags.isNaN && (a_inf || b_inf);
        s1_next.flags.isZero = a_zero && b_zero;
        s1_next.sign         = s1_next.flags.isInf ? (a_inf ? a_sign : b_sign)
                                                   : (swap ? b_sign : a_sign);
    end

    // ---------------- stage 2: add / subtract and normalise ----------------
    logic [M:0]              sum;
    logic [$clog2(M+1)-1:0]  lz;
    logic [31:0]             lz_ext, lim, shamt;
    logic                    sum_zero;

    assign sum = s1.eff_sub ? ({1'b0, s1.sig_big} - {1'b0, s1.sig_small})
                            : ({1'b0, s1.sig_big} + {1'b0, s1.sig_small});

    fpu_lzc #(.W(M)) u_lzc (
        .value (sum[M-1:0]),
        .count (lz)
    );

    always_comb begin
        sum_zero = (sum == '0);
        lz_ext   = 32'(lz);
        lim      = 32'(s1.exp) - 32'd1;
        shamt    = (lz_ext < lim) ? lz_ext : lim;

        s2_next       = '0;
        s2_next.valid = s1.valid;
        s2_next.tag   = s1.tag;
        s2_next.flags = s1.flags;
        if (sum[M]) begin
            s2_next.sig = sum[M:1] | {{(M-1){1'b0}}, sum[0]};
            s2_next.exp = s1.exp + EW'(1);
        end else begin
            // Clamped at exponent 1; a missing hidden bit then marks a subnormal.
            s2_next.sig = sum[M-1:0] << shamt;
            s2_next.exp = s1.exp - EW'(shamt);
        end
        s2_next.sign = (sum_zero && s1.eff_sub && !s1.flags.isInf) ? 1'b0 : s1.sign;
        s2_next.flags.isZero = s1.flags.isZero || sum_zero;
    end

    // ---------------- stage 3: round to nearest even and pack ----------------
    logic          round_up, inexact, hidden;
    logic [SW+1:0] mant;
    logic [EW:0]   exp_fin;
    logic [BW-1:0] res;
    logic [3:0]    cc;

    always_comb begin
        round_up = s2.sig[2] & (s2.sig[1] | s2.sig[0] | s2.sig[3]);
        inexact  = |s2.sig[2:0];
        mant     = {1'b0, s2.sig[M-1:FPU_GRS_W]} + {{(SW+1){1'b0}}, round_up};
        exp_fin  = {1'b0, s2.exp} + {{EW{1'b0}}, mant[SW+1]};
        hidden   = |mant[SW+1:SW];

        res = {s2.sign, hidden ? exp_fin[EW-1:0] : {EW{1'b0}}, mant[SW-1:0]};
        cc  = {(!hidden && (mant[SW-1:0] == '0)) || s2.flags.isZero, inexact, s2.sign, 1'b0};
        if (s2.flags.isNaN) begin
            res = QNAN;
            cc  = '0;
        end else if (s2.flags.isInf) begin
            res = {s2.sign, EXP_MAX, {SW{1'b0}}};
            cc  = {2'b00, s2.sign, 1'b0};
        end else if (exp_fin >= {1'b0, EXP_MAX}) begin
            res = {s2.sign, EXP_MAX, {SW{1'b0}}};
            cc  = {1'b0, inexact, s2.sign, 1'b1};
        end
    end

    // NOTE: only valid bits and visible outputs are reset; payload fields are don't-care while invalid.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1.valid  <= 1'b0;
            s2.valid  <= 1'b0;
            outValid  <= 1'b0;
            fpuOut    <= '0;
            condCodes <= '0;
            outTag    <= '0;
        end else if (advance) begin
            s1       <= s1_next;
            s2       <= s2_next;
            outValid <= s2.valid;
            if (s2.valid) begin
                fpuOut    <= res;
                condCodes <= cc;
                outTag    <= s2.tag;
            end
        end
    end

endmodule

// File: tb/tb_fpu_addsub_pipe.sv
// Directed bench for fpu_addsub_pipe at half precision: single ops, streams
// with and without backpressure, and a mid-stream reset flush.
module tb_fpu_addsub_pipe;
    import constants::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] fpu_in1, fpu_in2, fpu_out;
    fpuOp_t      op;
    logic [3:0]  in_tag, out_tag, cond_codes;

    int checks = 0;
    int errors = 0;

    logic [15:0] va [8];
    logic [15:0] vb [8];
    logic [15:0] vr [8];
    fpuOp_t      vo [8];

    always #5 clk = ~clk;

    fpu_addsub_pipe dut (
        .clock     (clk),
        .reset     (rst),
        .inValid   (in_valid),
        .inReady   (in_ready),
        .fpuIn1    (fpu_in1),
        .fpuIn2    (fpu_in2),
        .op        (op),
        .inTag     (in_tag),
        .outValid  (out_valid),
        .outReady  (out_ready),
        .fpuOut    (fpu_out),
        .condCodes (cond_codes),
        .outTag    (out_tag)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input fpuOp_t o,
                          input logic [3:0] tag, input logic [15:0] er,
                          input logic [3:0] ecc, input string name);
        int n;
        @(negedge clk);
        fpu_in1 = a; fpu_in2 = b; op = o; in_tag = tag; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({name, " latency"}, 32'(n), 32'd3);
        check({name, " result"}, 32'(fpu_out), 32'(er));
        check({name, " ZCNV"}, 32'(cond_codes), 32'(ecc));
        check({name, " tag"}, 32'(out_tag), 32'(tag));
    endtask

    task automatic stream(input bit random_ready, input string name);
        int          sent, recv;
        bit          stalled;
        logic [15:0] held_out;
        logic [3:0]  held_tag;
        logic [31:0] pat;
        pat = 32'hB2E59C6B;
        sent = 0; recv = 0; stalled = 1'b0; held_out = '0; held_tag = '0;
        for (int cyc = 0; cyc < 200 && recv < 8; cyc++) begin
            @(negedge clk);
            out_ready = random_ready ? pat[cyc % 32] : 1'b1;
            if (sent < 8) begin
                fpu_in1 = va[sent]; fpu_in2 = vb[sent]; op = vo[sent];
                in_tag = 4'(sent); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stalled) begin
                check({name, " held valid"}, 32'(out_valid), 32'd1);
                check({name, " held result"}, 32'(fpu_out), 32'(held_out));
                check({name, " held tag"}, 32'(out_tag), 32'(held_tag));
            end
            if (out_valid && out_ready) begin
                check({name, " result"}, 32'(fpu_out), 32'(vr[recv]));
                check({name, " tag"}, 32'(out_tag), 32'(recv));
                if (!random_ready) check({name, " arrival cycle"}, 32'(cyc), 32'(recv + 3));
                recv++;
            end
            if (in_valid && in_ready) sent++;
            stalled  = out_valid && !out_ready;
            held_out = fpu_out;
            held_tag = out_tag;
        end
        check({name, " results received"}, 32'(recv), 32'd8);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        int seen;
        va = '{16'h3C00, 16'h4000, 16'h3C00, 16'h3C00, 16'h3C01, 16'h0001, 16'h7BFF, 16'h7C00};
        vb = '{16'h0000, 16'h3C00, 16'h3C00, 16'h4000, 16'h1000, 16'h0001, 16'h7BFF, 16'hFC00};
        vo = '{FPU_ADD, FPU_ADD, FPU_SUB, FPU_SUB, FPU_ADD, FPU_ADD, FPU_ADD, FPU_ADD};
        vr = '{16'h3C00, 16'h4200, 16'h0000, 16'hBC00, 16'h3C02, 16'h0002, 16'h7C00, 16'h7E00};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        fpu_in1 = '0; fpu_in2 = '0; op = FPU_ADD; in_tag = '0;
        repeat (3) @(negedge clk);
        check("reset outValid", 32'(out_valid), 32'd0);
        check("reset fpuOut", 32'(fpu_out), 32'd0);
        check("reset condCodes", 32'(cond_codes), 32'd0);
        check("reset outTag", 32'(out_tag), 32'd0);
        check("reset inReady", 32'(in_ready), 32'd1);
        rst = 1'b0;

        run_op(16'h3C00, 16'h0000, FPU_ADD, 4'h1, 16'h3C00, 4'b0000, "1+0");
        run_op(16'h4000, 16'h3C00, FPU_ADD, 4'h2, 16'h4200, 4'b0000, "2+1");
        run_op(16'h3C00, 16'h3C00, FPU_SUB, 4'h3, 16'h0000, 4'b1000, "1-1");
        run_op(16'h3C00, 16'h4000, FPU_SUB, 4'h4, 16'hBC00, 4'b0010, "1-2");
        run_op(16'h8000, 16'h8000, FPU_ADD, 4'h5, 16'h8000, 4'b1010, "-0+-0");
        run_op(16'h3C00, 16'h1000, FPU_ADD, 4'h6, 16'h3C00, 4'b0100, "tie even");
        run_op(16'h3C01, 16'h1000, FPU_ADD, 4'h7, 16'h3C02, 4'b0100, "tie odd");
        run_op(16'h0001, 16'h0001, FPU_ADD, 4'h8, 16'h0002, 4'b0000, "subnormal sum");
        run_op(16'h0400, 16'h03FF, FPU_SUB, 4'h9, 16'h0001, 4'b0000, "normal-subnormal");
        run_op(16'h7BFF, 16'h7BFF, FPU_ADD, 4'hA, 16'h7C00, 4'b0001, "overflow");
        run_op(16'h7C00, 16'hFC00, FPU_ADD, 4'hB, 16'h7E00, 4'b0000, "inf-inf");
        run_op(16'h7E00, 16'h3C00, FPU_ADD, 4'hC, 16'h7E00, 4'b0000, "nan+1");
        run_op(16'hFC00, 16'h3C00, FPU_ADD, 4'hD, 16'hFC00, 4'b0010, "-inf+1");
        run_op(16'h3C00, 16'h3C00, fpuOp_t'(3'd7), 4'hE, 16'h4000, 4'b0000, "illegal op");

        stream(1'b0, "stream ready");
        stream(1'b1, "stream stall");

        // Three ops in flight with the oldest waiting at the output, then reset.
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fpu_in1 = va[i+1]; fpu_in2 = vb[i+1]; op = vo[i+1];
            in_tag = 4'(9 + i); in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("pre-flush result", 32'(fpu_out), 32'h4200);
        check("pre-flush tag", 32'(out_tag), 32'd9);
        rst = 1'b1;
        @(negedge clk);
        check("flush outValid", 32'(out_valid), 32'd0);
        check("flush fpuOut", 32'(fpu_out), 32'd0);
        check("flush condCodes", 32'(cond_codes), 32'd0);
        check("flush outTag", 32'(out_tag), 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flushed ops emitted", 32'(seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
